// File: rtl/udp_sched.sv
// udp_sched: grants the shared MAC either to RX command handling
// (mac2fifoc copy, then fifoc2cs parse) or to TX upload (fs_udp_tx).
// It drives all fs/fd handshakes, guards every phase with a watchdog
// and keeps rx/tx/error counters for the LED register view.
//
// Ports
//   clk, rst_n               clock, asynchronous active-low reset
//   fifo_ok                  no FIFO full; new grants only while high
//   fs_udp_rx / fd_udp_rx    MAC command frame available / frame consumed
//   fs_mac2fifoc / fd_...    copy MAC buffer -> fifoc start / done
//   fs_fifoc2cs / fd_...     command parse start / done
//   tx_req, tx_len           upload pending, payload bytes (sampled at grant)
//   fs_udp_tx / fd_udp_tx    UDP transmit start / done
//   udp_tx_len               tx_len latched at grant
//   busy, err                not idle, one-cycle watchdog abort pulse
//   rx_cnt, tx_cnt, err_cnt  completions (wrapping), aborts (saturating)
module udp_sched #(
    parameter int unsigned     TO_W      = 20,
    parameter logic [TO_W-1:0] TO_CYCLES = TO_W'(1000000)
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        fifo_ok,
    input  logic        fs_udp_rx,
    output logic        fd_udp_rx,
    output logic        fs_mac2fifoc,
    input  logic        fd_mac2fifoc,
    output logic        fs_fifoc2cs,
    input  logic        fd_fifoc2cs,
    input  logic        tx_req,
    input  logic [11:0] tx_len,
    output logic        fs_udp_tx,
    input  logic        fd_udp_tx,
    output logic [11:0] udp_tx_len,
    output logic        busy,
    output logic        err,
    output logic [7:0]  rx_cnt,
    output logic [7:0]  tx_cnt,
    output logic [7:0]  err_cnt
);

    localparam int unsigned LEN_W = 12;
    localparam int unsigned CNT_W = 8;
    localparam logic [TO_W-1:0] WD_LAST = TO_CYCLES - TO_W'(1);

    typedef enum logic [3:0] {
        ST_IDLE = 4'h8,
        ST_RXCP = 4'h9,
        ST_RXAK = 4'hA,
        ST_RXPS = 4'hB,
        ST_TXST = 4'hC,
        ST_DONE = 4'hD
    } state_e;

    state_e             state_q, state_d;
    logic               last_rx_q, last_rx_d;
    logic [TO_W-1:0]    wd_q, wd_d;

    logic               fd_udp_rx_q, fs_mac2fifoc_q, fs_fifoc2cs_q, fs_udp_tx_q;
    logic               busy_q, err_q;
    logic [LEN_W-1:0]   udp_tx_len_q;
    logic [CNT_W-1:0]   rx_cnt_q, tx_cnt_q, err_cnt_q;

    logic rx_c, tx_c, expire_c, fds_low_c;
    logic abort_c, rx_done_c, tx_done_c, tx_grant_c;

    // Request qualification; a zero-length upload is never eligible.
    assign rx_c      = fs_udp_rx;
    assign tx_c      = tx_req && (tx_len != '0);
    assign expire_c  = (wd_q == WD_LAST);
    assign fds_low_c = !(fd_mac2fifoc || fd_fifoc2cs || fd_udp_tx);

    // Next state; a phase's own done condition is checked before expiry so fd wins a tie.
    always_comb begin
        state_d    = state_q;
        last_rx_d  = last_rx_q;
        abort_c    = 1'b0;
        rx_done_c  = 1'b0;
        tx_done_c  = 1'b0;
        tx_grant_c = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (fifo_ok) begin
                    // Round robin when both pend: RX unless RX was granted last.
                    if (rx_c && (!tx_c || !last_rx_q)) begin
                        state_d   = ST_RXCP;
                        last_rx_d = 1'b1;
                    end else if (tx_c) begin
                        state_d    = ST_TXST;
                        last_rx_d  = 1'b0;
                        tx_grant_c = 1'b1;
                    end
                end
            end
            ST_RXCP: begin
                if (fd_mac2fifoc) begin
                    state_d = ST_RXAK;
                end else if (expire_c) begin
                    state_d = ST_DONE;
                    abort_c = 1'b1;
                end
            end
            ST_RXAK: begin
                if (!fs_udp_rx) begin
                    state_d = ST_RXPS;
                end else if (expire_c) begin
                    state_d = ST_DONE;
                    abort_c = 1'b1;
                end
            end
            ST_RXPS: begin
                if (fd_fifoc2cs) begin
                    state_d   = ST_DONE;
                    rx_done_c = 1'b1;
                end else if (expire_c) begin
                    state_d = ST_DONE;
                    abort_c = 1'b1;
                end
            end
            ST_TXST: begin
                if (fd_udp_tx) begin
                    state_d   = ST_DONE;
                    tx_done_c = 1'b1;
                end else if (expire_c) begin
                    state_d = ST_DONE;
                    abort_c = 1'b1;
                end
            end
            ST_DONE: begin
                // Wait for every fd to drop; a stuck fd is abandoned on expiry.
                if (fds_low_c) begin
                    state_d = ST_IDLE;
                end else if (expire_c) begin
                    state_d = ST_IDLE;
                    abort_c = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Watchdog restarts on every state change and idles at zero.
        if ((state_d != state_q) || (state_q == ST_IDLE)) begin
            wd_d = '0;
        end else begin
            wd_d = wd_q + TO_W'(1);
        end
    end

    // State, watchdog, counters and registered output decodes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= ST_IDLE;
            last_rx_q      <= 1'b0;
            wd_q           <= '0;
            fd_udp_rx_q    <= 1'b0;
            fs_mac2fifoc_q <= 1'b0;
            fs_fifoc2cs_q  <= 1'b0;
            fs_udp_tx_q    <= 1'b0;
            busy_q         <= 1'b0;
            err_q          <= 1'b0;
            udp_tx_len_q   <= '0;
            rx_cnt_q       <= '0;
            tx_cnt_q       <= '0;
            err_cnt_q      <= '0;
        end else begin
            state_q        <= state_d;
            last_rx_q      <= last_rx_d;
            wd_q           <= wd_d;
            fs_mac2fifoc_q <= (state_q == ST_RXCP);
            fd_udp_rx_q    <= (state_q == ST_RXAK);
            fs_fifoc2cs_q  <= (state_q == ST_RXPS);
            fs_udp_tx_q    <= (state_q == ST_TXST);
            busy_q         <= (state_q != ST_IDLE);
            err_q          <= abort_c;
            if (tx_grant_c) begin
                udp_tx_len_q <= tx_len;
            end
            if (rx_done_c) begin
                rx_cnt_q <= rx_cnt_q + CNT_W'(1);
            end
            if (tx_done_c) begin
                tx_cnt_q <= tx_cnt_q + CNT_W'(1);
            end
            if (abort_c && (err_cnt_q != {CNT_W{1'b1}})) begin
                err_cnt_q <= err_cnt_q + CNT_W'(1);
            end
        end
    end

    assign fd_udp_rx    = fd_udp_rx_q;
    assign fs_mac2fifoc = fs_mac2fifoc_q;
    assign fs_fifoc2cs  = fs_fifoc2cs_q;
    assign fs_udp_tx    = fs_udp_tx_q;
    assign busy         = busy_q;
    assign err          = err_q;
    assign udp_tx_len   = udp_tx_len_q;
    assign rx_cnt       = rx_cnt_q;
    assign tx_cnt       = tx_cnt_q;
    assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_udp_sched.sv
// tb_udp_sched: directed and randomized transactions against udp_sched.
// A transaction-level model tracks pending requests, round-robin order,
// latched upload length and the expected counter values.
module tb_udp_sched;

    localparam int unsigned     TO_W   = 20;
    localparam logic [TO_W-1:0] TO_CYC = 20'd16;

    localparam int S_FS_CP = 0;
    localparam int S_FD_RX = 1;
    localparam int S_FS_PS = 2;
    localparam int S_FS_TX = 3;
    localparam int S_BUSY  = 4;
    localparam int S_ERR   = 5;
    localparam int S_ANY   = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fifo_ok;
    logic        fs_udp_rx;
    logic        fd_udp_rx;
    logic        fs_mac2fifoc;
    logic        fd_mac2fifoc;
    logic        fs_fifoc2cs;
    logic        fd_fifoc2cs;
    logic        tx_req;
    logic [11:0] tx_len;
    logic        fs_udp_tx;
    logic        fd_udp_tx;
    logic [11:0] udp_tx_len;
    logic        busy;
    logic        err;
    logic [7:0]  rx_cnt;
    logic [7:0]  tx_cnt;
    logic [7:0]  err_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int err_hi      = 0;

    // Reference model state
    int          m_rx      = 0;
    int          m_tx      = 0;
    int          m_err     = 0;
    bit          m_last_rx = 1'b0;
    bit          rx_pend   = 1'b0;
    bit          tx_pend   = 1'b0;
    logic [11:0] m_len     = '0;

    udp_sched #(.TO_W(TO_W), .TO_CYCLES(TO_CYC)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fifo_ok      (fifo_ok),
        .fs_udp_rx    (fs_udp_rx),
        .fd_udp_rx    (fd_udp_rx),
        .fs_mac2fifoc (fs_mac2fifoc),
        .fd_mac2fifoc (fd_mac2fifoc),
        .fs_fifoc2cs  (fs_fifoc2cs),
        .fd_fifoc2cs  (fd_fifoc2cs),
        .tx_req       (tx_req),
        .tx_len       (tx_len),
        .fs_udp_tx    (fs_udp_tx),
        .fd_udp_tx    (fd_udp_tx),
        .udp_tx_len   (udp_tx_len),
        .busy         (busy),
        .err          (err),
        .rx_cnt       (rx_cnt),
        .tx_cnt       (tx_cnt),
        .err_cnt      (err_cnt)
    );

    always #5 clk = ~clk;

    // Count cycles with err high; each abort must contribute exactly one.
    always @(negedge clk) if (err === 1'b1) err_hi++;

    initial begin
        #500000;
        $display("FAIL global_timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic sig(input int idx);
        case (idx)
            S_FS_CP: return fs_mac2fifoc;
            S_FD_RX: return fd_udp_rx;
            S_FS_PS: return fs_fifoc2cs;
            S_FS_TX: return fs_udp_tx;
            S_BUSY:  return busy;
            S_ERR:   return err;
            default: return fs_mac2fifoc | fs_udp_tx;
        endcase
    endfunction

    // Ticks until the selected output reaches val, at most max ticks.
    task automatic wait_sig(input int idx, input logic val, input int max, output int n);
        n = 0;
        while ((sig(idx) !== val) && (n < max)) begin
            tick();
            n++;
        end
    endtask

    task automatic raise_rx();
        fs_udp_rx = 1'b1;
        rx_pend   = 1'b1;
    endtask

    task automatic raise_tx(input logic [11:0] len);
        tx_req = 1'b1;
        tx_len = len;
        if (len != 12'd0) begin
            tx_pend = 1'b1;
            m_len   = len;
        end
    endtask

    // Serve one grant as MAC/parser/transmitter with the given delays.
    task automatic serve(input int d_a, input int d_b, input int d_c, input bit jitter,
                         output int lat);
        int n;
        bit exp_tx;
        exp_tx = tx_pend && (!rx_pend || m_last_rx);
        wait_sig(S_ANY, 1'b1, 64, lat);
        chk("grant_tx", 32'(fs_udp_tx), 32'(exp_tx));
        chk("grant_rx", 32'(fs_mac2fifoc), 32'(!exp_tx));
        if (jitter) fifo_ok = 1'($urandom_range(0, 1));
        if (!exp_tx) begin
            repeat (d_a) tick();
            fd_mac2fifoc = 1'b1;
            wait_sig(S_FD_RX, 1'b1, 64, n);
            chk("rxak_lat", n, 2);
            chk("rxcp_fs_drop", 32'(fs_mac2fifoc), 0);
            fd_mac2fifoc = 1'b0;
            repeat (d_b) tick();
            fs_udp_rx = 1'b0;
            rx_pend   = 1'b0;
            wait_sig(S_FS_PS, 1'b1, 64, n);
            chk("rxps_lat", n, 2);
            chk("rxak_drop", 32'(fd_udp_rx), 0);
            repeat (d_c) tick();
            fd_fifoc2cs = 1'b1;
            wait_sig(S_FS_PS, 1'b0, 64, n);
            chk("rxps_fall_lat", n, 2);
            m_rx++;
            chk("rx_cnt", 32'(rx_cnt), 32'(8'(m_rx)));
            chk("done_busy", 32'(busy), 1);
            fd_fifoc2cs = 1'b0;
            m_last_rx   = 1'b1;
        end else begin
            chk("tx_len_grant", 32'(udp_tx_len), 32'(m_len));
            if (jitter) tx_len = 12'($urandom);
            repeat (d_a) tick();
            fd_udp_tx = 1'b1;
            wait_sig(S_FS_TX, 1'b0, 64, n);
            chk("tx_fall_lat", n, 2);
            m_tx++;
            chk("tx_cnt", 32'(tx_cnt), 32'(8'(m_tx)));
            chk("tx_len_hold", 32'(udp_tx_len), 32'(m_len));
            fd_udp_tx = 1'b0;
            tx_req    = 1'b0;
            tx_pend   = 1'b0;
            m_last_rx = 1'b0;
        end
        wait_sig(S_BUSY, 1'b0, 64, n);
        chk("idle_lat", n, 2);
    endtask

    initial begin
        int          n;
        int          lat;
        logic        bad;
        logic [11:0] len;

        rst_n        = 1'b0;
        fifo_ok      = 1'b0;
        fs_udp_rx    = 1'b0;
        fd_mac2fifoc = 1'b0;
        fd_fifoc2cs  = 1'b0;
        tx_req       = 1'b0;
        tx_len       = '0;
        fd_udp_tx    = 1'b0;

        // Reset values
        repeat (3) tick();
        chk("rst_flags", 32'({fd_udp_rx, fs_mac2fifoc, fs_fifoc2cs, fs_udp_tx, busy, err}), 0);
        chk("rst_len", 32'(udp_tx_len), 0);
        chk("rst_cnts", 32'({rx_cnt, tx_cnt, err_cnt}), 0);
        rst_n   = 1'b1;
        fifo_ok = 1'b1;
        tick();
        tick();
        chk("idle_after_rst", 32'(busy), 0);

        // Arbitration: both pending, twice -> RX,TX,RX,TX
        for (int r = 0; r < 2; r++) begin
            raise_rx();
            raise_tx(12'd64);
            serve(1, 1, 1, 1'b0, lat);
            chk("arb_first_lat", lat, 2);
            serve(2, 0, 3, 1'b0, lat);
        end
        chk("arb_rx_cnt", 32'(rx_cnt), 2);
        chk("arb_tx_cnt", 32'(tx_cnt), 2);

        // Plain RX flow with the reference delays
        raise_rx();
        serve(5, 3, 4, 1'b0, lat);
        chk("rx_grant_lat", lat, 2);
        chk("rx_no_err", err_hi, 0);

        // fifo_ok gating and zero-length upload
        fifo_ok = 1'b0;
        raise_rx();
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (busy || fs_mac2fifoc) bad = 1'b1;
        end
        chk("gate_fifo_ok", 32'(bad), 0);
        fifo_ok = 1'b1;
        serve(0, 0, 0, 1'b0, lat);
        chk("gate_release_lat", lat, 2);
        raise_tx(12'd0);
        bad = 1'b0;
        repeat (20) begin
            tick();
            if (busy || fs_udp_tx) bad = 1'b1;
        end
        chk("zero_len_never", 32'(bad), 0);
        tx_req = 1'b0;

        // Randomized traffic
        for (int it = 0; it < 24; it++) begin
            fifo_ok = 1'b1;
            if (!rx_pend && !tx_pend) begin
                len = 12'($urandom_range(1, 4095));
                case ($urandom_range(0, 3))
                    0: raise_rx();
                    1: raise_tx(len);
                    2: begin raise_rx(); raise_tx(len); end
                    default: begin raise_rx(); raise_tx(12'd0); end
                endcase
            end
            serve(int'($urandom_range(0, 6)), int'($urandom_range(0, 6)),
                  int'($urandom_range(0, 6)), 1'b1, lat);
            if (!tx_pend) begin
                tx_req = 1'b0;
                tx_len = '0;
            end
        end
        fifo_ok = 1'b1;
        if (rx_pend || tx_pend) serve(1, 1, 1, 1'b0, lat);
        tx_req = 1'b0;
        chk("rand_no_err", err_hi, 0);

        // Watchdog abort in RXCP
        raise_rx();
        wait_sig(S_FS_CP, 1'b1, 64, n);
        chk("wd_grant_lat", n, 2);
        wait_sig(S_ERR, 1'b1, 64, n);
        chk("wd_err_at", n, 15);
        chk("wd_fs_still", 32'(fs_mac2fifoc), 1);
        m_err++;
        chk("wd_err_cnt", 32'(err_cnt), 32'(8'(m_err)));
        fs_udp_rx = 1'b0;
        rx_pend   = 1'b0;
        m_last_rx = 1'b1;
        tick();
        chk("wd_err_pulse", 32'(err), 0);
        chk("wd_fs_drop", 32'(fs_mac2fifoc), 0);
        wait_sig(S_BUSY, 1'b0, 64, n);
        chk("wd_back_idle", n, 1);
        chk("wd_rx_cnt", 32'(rx_cnt), 32'(8'(m_rx)));
        chk("wd_err_width", err_hi, m_err);

        // fd_udp_tx on the expiry cycle: completion wins
        raise_tx(12'd300);
        wait_sig(S_FS_TX, 1'b1, 64, n);
        chk("race_grant_lat", n, 2);
        repeat (14) tick();
        fd_udp_tx = 1'b1;
        tick();
        chk("race_no_err", 32'(err), 0);
        m_tx++;
        chk("race_tx_cnt", 32'(tx_cnt), 32'(8'(m_tx)));
        chk("race_err_cnt", 32'(err_cnt), 32'(8'(m_err)));
        tick();
        chk("race_fs_drop", 32'(fs_udp_tx), 0);
        fd_udp_tx = 1'b0;
        tx_req    = 1'b0;
        tx_pend   = 1'b0;
        m_last_rx = 1'b0;
        wait_sig(S_BUSY, 1'b0, 64, n);
        chk("race_idle", n, 2);
        chk("race_err_total", err_hi, m_err);

        // Asynchronous reset mid-TXST
        raise_tx(12'd77);
        wait_sig(S_FS_TX, 1'b1, 64, n);
        chk("arst_grant", 32'(fs_udp_tx), 1);
        #1;
        rst_n = 1'b0;
        #2;
        chk("arst_fs", 32'(fs_udp_tx), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_cnts", 32'({rx_cnt, tx_cnt, err_cnt}), 0);
        chk("arst_len", 32'(udp_tx_len), 0);
        tx_req  = 1'b0;
        tx_len  = '0;
        tx_pend = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        tick();
        chk("arst_idle", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
